pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Next-PC controller for the fetch stage. Drives the data input and load enable of the 32-bit program counter register, and sequences instruction-memory fetches with a req/ready handshake. Arbitrates the sequential, branch, jump and jump-register sources and honours hazard-unit stalls. Flags misaligned redirect targets with a sticky fault.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address loaded after reset
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pc_cur  in  32  current PC, from the PC register output
- stall  in  1  hazard unit: hold fetch
- branch_taken  in  1  EX-stage branch resolved taken
- branch_target  in  32  branch target
- jr  in  1  jump-register in ID
- jr_target  in  32  register-sourced target
- jump  in  1  J/JAL in ID
- jump_target  in  32  immediate jump target
- imem_ready  in  1  instruction memory completes the current request this cycle
- pc_next  out  32  to PC register data input
- pc_enable  out  1  to PC register load enable
- imem_req  out  1  fetch request at pc_cur
- flush  out  1  squash the instruction in IF/ID
- misaligned  out  1  sticky fault, misaligned redirect

## Operation
- Redirect priority: branch_taken > jr > jump. "Redirect" means any of the three is asserted; its target is the winner's target.
- Sequential next PC = pc_cur + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Pending register: one valid bit plus 32-bit target. A redirect arriving while a fetch is outstanding is held here. A newer redirect overwrites an older pending one. A live redirect input in the same cycle takes precedence over the pending value.
- States:
  - BOOT: pc_next=RESET_VECTOR, pc_enable=1, imem_req=0 -> FETCH.
  - FETCH: imem_req=1.
    - imem_ready=0: pc_enable=0; capture any redirect into pending.
    - imem_ready=1 and (redirect or pending valid): pc_next=target, pc_enable=1, flush=1, clear pending; stay FETCH.
    - imem_ready=1, no redirect, stall=1: pc_enable=0 -> STALLED.
    - imem_ready=1, otherwise: pc_next=pc_cur+4, pc_enable=1.
  - STALLED: imem_req=0.
    - Redirect: pc_next=target, pc_enable=1, flush=1 -> FETCH. Redirect beats stall.
    - Else stall=0: pc_next=pc_cur+4, pc_enable=1 -> FETCH.
    - Else: pc_enable=0.
  - FAULT: pc_enable=0, imem_req=0, flush=0, misaligned=1. Exits only on reset.
- Misalignment: when a redirect target with bits [1:0] != 0 would be applied, pc_enable=0, flush=1 for that cycle -> FAULT. The target is never loaded.
- Outputs not listed for a state are 0. pc_next=pc_cur+4 when pc_enable=0.

## Timing
- While reset=1: state BOOT, pending cleared, pc_enable=0, imem_req=0, flush=0, misaligned=0, pc_next=RESET_VECTOR.
- Reset asserted mid-fetch or in FAULT: the next edge returns to BOOT and discards pending.
- First cycle after reset deasserts: BOOT loads RESET_VECTOR. imem_req rises one cycle later.
- pc_enable is combinational from state and inputs. The PC register updates on the same edge, so pc_cur shows the new value one cycle later.
- Zero-wait memory (imem_ready held high): one PC advance per cycle, so pc_cur steps +4 every cycle.
- A redirect produces flush for exactly one cycle, coincident with the pc_enable that loads the target.
- pc_enable is never asserted in FETCH while imem_ready=0, so the address presented to memory is stable for the whole request.

## Test plan
- Reset then free-run, RESET_VECTOR=0x100, imem_ready=1 -> pc_cur sequence 0x100, 0x104, 0x108…; flush never asserts.
- Branch during wait: imem_ready low for 3 cycles; branch_taken=1 to 0x400 in cycle 1 only; then imem_ready=1 -> single pc_enable with pc_next=0x400 and flush=1 on the ready cycle.
- Simultaneous branch_taken (0x200), jr (0x300) and jump (0x500) -> pc_next=0x200.
- Stall for 4 cycles after a completed fetch -> imem_req=0 and pc_enable=0 throughout; release -> pc_next=pc_cur+4. A jump during the stall -> immediate load of the target with flush=1.
- Wrap and fault:
  - pc_cur=0xFFFF_FFFC, sequential -> pc_next=0.
  - jump_target=0x102 -> misaligned=1 sticky, PC not loaded, no further imem_req until reset.
  - Reset asserted mid-wait -> BOOT on the next edge, pending discarded.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the fetch stage.
// It picks the next program counter from the sequential, branch, jump-register
// and jump sources, and runs instruction-memory fetches with a req/ready
// handshake. It honours hazard-unit stalls. A misaligned redirect target is
// never loaded: it sends the block into a sticky FAULT state that only reset clears.
//
// state    | meaning
// ---------+------------------------------------------------------------
// BOOT     | load RESET_VECTOR into the PC, no fetch yet
// FETCH    | request outstanding at pc_cur, waiting for imem_ready
// STALLED  | fetch done, hazard unit holding the PC, no request
// FAULT    | misaligned redirect seen, everything frozen until reset
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_cur,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        imem_ready,
  output logic [31:0] pc_next,
  output logic        pc_enable,
  output logic        imem_req,
  output logic        flush,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_STALLED = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] apply_target;
  logic [31:0] pc_seq;

  // Redirect arbitration: branch beats jr beats jump. A live redirect also
  // beats whatever is sitting in the pending register.
  always_comb begin
    redirect        = branch_taken | jr | jump;
    redirect_target = jump_target;
    if (branch_taken) begin
      redirect_target = branch_target;
    end else if (jr) begin
      redirect_target = jr_target;
    end
    apply_target = redirect ? redirect_target : pend_target_q;
    pc_seq       = pc_cur + 32'd4;
  end

  // Next-state, pending-register update and output decode.
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pc_next       = pc_seq;
    pc_enable     = 1'b0;
    imem_req      = 1'b0;
    flush         = 1'b0;
    misaligned    = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        pc_next   = RESET_VECTOR;
        pc_enable = 1'b1;
        state_d   = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          // Address must stay stable while the request is open, so any
          // redirect is parked and applied when the fetch completes.
          if (redirect) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redirect_target;
          end
        end else if (redirect || pend_valid_q) begin
          pend_valid_d = 1'b0;
          flush        = 1'b1;
          if (apply_target[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else begin
            pc_next   = apply_target;
            pc_enable = 1'b1;
          end
        end else if (stall) begin
          state_d = ST_STALLED;
        end else begin
          pc_enable = 1'b1;
        end
      end

      ST_STALLED: begin
        if (redirect) begin
          flush = 1'b1;
          if (redirect_target[1:0] != 2'b00) begin
            state_d = ST_FAULT;
          end else begin
            pc_next   = redirect_target;
            pc_enable = 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (!stall) begin
          pc_enable = 1'b1;
          state_d   = ST_FETCH;
        end
      end

      ST_FAULT: begin
        misaligned = 1'b1;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Reset forces the quiet output set immediately, not one cycle later.
    if (reset) begin
      pc_next      = RESET_VECTOR;
      pc_enable    = 1'b0;
      imem_req     = 1'b0;
      flush        = 1'b0;
      misaligned   = 1'b0;
      state_d      = ST_BOOT;
      pend_valid_d = 1'b0;
    end
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. It holds the PC register itself, runs directed
// scenarios and then randomized traffic, and compares every cycle against a
// behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_cur;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        pc_enable;
  logic        imem_req;
  logic        flush;
  logic        misaligned;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .pc_cur(pc_cur), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
    .imem_ready(imem_ready), .pc_next(pc_next), .pc_enable(pc_enable),
    .imem_req(imem_req), .flush(flush), .misaligned(misaligned)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: mode 0 boot, 1 fetching, 2 held by stall, 3 faulted.
  int          m_mode = 0;
  bit          m_pv = 0;
  logic [31:0] m_pt = '0;
  int          n_mode;
  bit          n_pv;
  logic [31:0] n_pt;
  logic [31:0] e_next;
  bit          e_en, e_req, e_flush, e_mis;

  task automatic model_eval();
    bit          any;
    logic [31:0] win, t;
    any = branch_taken || jr || jump;
    win = branch_taken ? branch_target : (jr ? jr_target : jump_target);
    n_mode = m_mode; n_pv = m_pv; n_pt = m_pt;
    e_next = pc_cur + 32'd4; e_en = 0; e_req = 0; e_flush = 0; e_mis = 0;
    if (reset) begin
      e_next = RV; n_mode = 0; n_pv = 0;
    end else if (m_mode == 3) begin
      e_mis = 1;
    end else if (m_mode == 0) begin
      e_next = RV; e_en = 1; n_mode = 1;
    end else begin
      e_req = (m_mode == 1);
      if (m_mode == 1 && !imem_ready) begin
        if (any) begin n_pv = 1; n_pt = win; end
      end else if (any || (m_mode == 1 && m_pv)) begin
        t = any ? win : m_pt;
        n_pv = 0; e_flush = 1;
        if (t % 4 != 0) n_mode = 3;
        else begin e_next = t; e_en = 1; n_mode = 1; end
      end else if (stall) begin
        n_mode = 2;
      end else begin
        e_en = 1; n_mode = 1;
      end
    end
  endtask

  // One clock: compare against the model, clock the DUT, update the PC register.
  task automatic step();
    bit          s_en;
    logic [31:0] s_next;
    #1;
    model_eval();
    check("pc_next", pc_next, e_next);
    check("pc_enable", {31'b0, pc_enable}, {31'b0, e_en});
    check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    check("flush", {31'b0, flush}, {31'b0, e_flush});
    check("misaligned", {31'b0, misaligned}, {31'b0, e_mis});
    s_en = pc_enable; s_next = pc_next;
    @(posedge clk);
    m_mode = n_mode; m_pv = n_pv; m_pt = n_pt;
    #1;
    if (s_en) pc_cur = s_next;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; branch_taken = 0; jr = 0; jump = 0;
    branch_target = '0; jr_target = '0; jump_target = '0;
  endtask

  initial begin
    logic [31:0] hold_pc, r;
    reset = 1; pc_cur = 32'hDEAD_BEE0; imem_ready = 1;
    idle_inputs();
    @(negedge clk);

    // Reset behaviour.
    #1;
    check("rst_pc_next", pc_next, RV);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    step(); step();

    // Boot then zero-wait free-run.
    reset = 0;
    #1;
    check("boot_en", {31'b0, pc_enable}, 32'd1);
    step();
    for (int k = 0; k < 8; k++) begin
      check("seq_pc", pc_cur, RV + 32'(4 * k));
      check("seq_noflush", {31'b0, flush}, 32'd0);
      step();
    end

    // Branch during a 3-cycle wait, applied on the ready cycle.
    imem_ready = 0; branch_taken = 1; branch_target = 32'h400;
    step();
    branch_taken = 0;
    step(); step();
    imem_ready = 1;
    #1;
    check("pend_pc_next", pc_next, 32'h400);
    check("pend_flush", {31'b0, flush}, 32'd1);
    step();
    check("pend_loaded", pc_cur, 32'h400);

    // Simultaneous redirect sources.
    branch_taken = 1; branch_target = 32'h200;
    jr = 1; jr_target = 32'h300; jump = 1; jump_target = 32'h500;
    #1;
    check("prio_pc_next", pc_next, 32'h200);
    step();
    idle_inputs();

    // Stall after a completed fetch, release, then jump during stall.
    stall = 1;
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("stall_req", {31'b0, imem_req}, 32'd0);
      check("stall_en", {31'b0, pc_enable}, 32'd0);
      step();
    end
    stall = 0;
    #1;
    check("release_pc", pc_next, pc_cur + 32'd4);
    step();
    stall = 1;
    step();
    jump = 1; jump_target = 32'h800;
    #1;
    check("stall_jump_pc", pc_next, 32'h800);
    check("stall_jump_flush", {31'b0, flush}, 32'd1);
    step();
    idle_inputs();

    // Sequential wrap.
    pc_cur = 32'hFFFF_FFFC;
    #1;
    check("wrap", pc_next, 32'h0);
    step();

    // Reset mid-wait discards a pending redirect.
    imem_ready = 0; branch_taken = 1; branch_target = 32'h600;
    step();
    branch_taken = 0; reset = 1;
    step();
    reset = 0;
    step();
    imem_ready = 1;
    #1;
    check("no_pend_pc", pc_next, pc_cur + 32'd4);
    check("no_pend_flush", {31'b0, flush}, 32'd0);
    step();

    // Misaligned jump target: sticky fault, PC frozen.
    hold_pc = pc_cur;
    jump = 1; jump_target = 32'h102;
    #1;
    check("mis_en", {31'b0, pc_enable}, 32'd0);
    step();
    jump = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("fault_sticky", {31'b0, misaligned}, 32'd1);
      check("fault_req", {31'b0, imem_req}, 32'd0);
      step();
    end
    check("fault_pc_hold", pc_cur, hold_pc);
    reset = 1;
    step();
    reset = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(0, (m_mode == 3) ? 15 : 199) == 0);
      imem_ready = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      jr = ($urandom_range(0, 9) == 0);
      jump = ($urandom_range(0, 9) == 0);
      r = $urandom; branch_target = ($urandom_range(0, 19) == 0) ? r : (r & ~32'h3);
      r = $urandom; jr_target = ($urandom_range(0, 19) == 0) ? r : (r & ~32'h3);
      r = $urandom; jump_target = ($urandom_range(0, 19) == 0) ? r : (r & ~32'h3);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
